// File: rtl/cmd_pkg.sv
// Shared command-engine constants: command bytes, response codes, FSM states.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    SEND,
    PULSE_HI,
    PULSE_LO,
    RUN,
    RSTP
  } state_e;

  typedef enum logic [1:0] {
    PS_CLK,
    PS_ICLK,
    PS_RST
  } psel_e;

  localparam logic [7:0] CMD_ADDR  = "A";
  localparam logic [7:0] CMD_DATA  = "B";
  localparam logic [7:0] CMD_MASK  = "M";
  localparam logic [7:0] CMD_OUT   = "O";
  localparam logic [7:0] CMD_FLOAT = "f";
  localparam logic [7:0] CMD_RDA   = "a";
  localparam logic [7:0] CMD_RDD   = "b";
  localparam logic [7:0] CMD_RDF   = "s";
  localparam logic [7:0] CMD_ID    = "I";
  localparam logic [7:0] CMD_NOP   = "N";
  localparam logic [7:0] CMD_NOP2  = 8'hFF;
  localparam logic [7:0] CMD_CLK   = "c";
  localparam logic [7:0] CMD_ICLK  = "C";
  localparam logic [7:0] CMD_TCYC  = "T";
  localparam logic [7:0] CMD_RST   = "Z";
  localparam logic [7:0] CMD_RUN   = "R";

  localparam logic [7:0] RSP_BRK   = "K";
  localparam logic [7:0] RSP_HLT   = "H";
  localparam logic [7:0] RSP_ABORT = "X";
  localparam logic [7:0] RSP_UNK   = "?";
  localparam logic [7:0] RSP_ID0   = "V";
  localparam logic [7:0] RSP_ID1   = "M";

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_gen.sv
// One-shot CPU pulse: PW cycles high then PW low; reset pulses skip the low phase.
module pulse_gen
  import cmd_pkg::*;
#(
  parameter int PW = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  psel_e sel,
  output logic  busy,
  output logic  clk_p,
  output logic  iclk_p,
  output logic  rst_p
);

  localparam int CNTW = (PW > 1) ? $clog2(PW) : 1;

  logic [CNTW-1:0] cnt_q;
  logic            busy_q;
  logic            hi_q;
  psel_e           sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= 1'b0;
      sel_q  <= PS_CLK;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        hi_q   <= 1'b1;
        cnt_q  <= CNTW'(PW - 1);
        sel_q  <= sel;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end else if (hi_q && sel_q != PS_RST) begin
      hi_q  <= 1'b0;
      cnt_q <= CNTW'(PW - 1);
    end else begin
      busy_q <= 1'b0;
      hi_q   <= 1'b0;
    end
  end

  assign busy   = busy_q;
  assign clk_p  = busy_q && hi_q && sel_q == PS_CLK;
  assign iclk_p = busy_q && hi_q && sel_q == PS_ICLK;
  assign rst_p  = busy_q && hi_q && sel_q == PS_RST;

endmodule

// File: rtl/cmd_engine.sv
// Byte-stream debug engine: forces CPU buses, pulses CPU clocks, runs to break.
module cmd_engine
  import cmd_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int CW = 32,
  parameter int FW = 4,
  parameter int PW = 2,
  parameter logic [CW-1:0] CW_DEFAULT = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  input  logic [FW-1:0] flags_in,
  input  logic          brk,
  input  logic          hlt,
  output logic [AW-1:0] addr_out,
  output logic          addr_oe,
  output logic [DW-1:0] data_out,
  output logic          data_oe,
  output logic [CW-1:0] ctrl_word,
  output logic          ctrl_en,
  output logic          cpu_clk,
  output logic          cpu_iclk,
  output logic          cpu_rst
);

  localparam int AB  = nbytes(AW);
  localparam int DB  = nbytes(DW);
  localparam int CB  = nbytes(CW);
  localparam int FB  = nbytes(FW);
  localparam int AGB = maxi(maxi(AB, DB), CB);
  localparam int RB  = maxi(maxi(AB, DB), maxi(FB, 3));
  localparam int AGW = AGB * 8;
  localparam int RBW = RB * 8;
  localparam int IW  = $clog2(AGB + 1);
  localparam int RNW = $clog2(RB + 1);

  state_e          state_q;
  logic [7:0]      op_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   arg_n;
  logic [AGW-1:0]  arg_q;
  logic [AGW-1:0]  arg_nx;
  logic [RBW-1:0]  resp_q;
  logic [RBW-1:0]  rr;
  logic [RNW-1:0]  rn_q;
  logic [RNW-1:0]  rn;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [CW-1:0]   cw_q;
  logic            aoe_q, doe_q, cen_q;
  logic [7:0]      txd_q;
  logic            txv_q;
  logic            live_q;
  logic            start_q;
  logic            second_q;
  psel_e           psel_q;
  logic            pg_busy, pg_clk, pg_iclk, pg_rst;
  logic            accept, arg_last;

  pulse_gen #(.PW(PW)) u_pulse (
    .clk    (clk),
    .rst    (rst),
    .start  (start_q),
    .sel    (psel_q),
    .busy   (pg_busy),
    .clk_p  (pg_clk),
    .iclk_p (pg_iclk),
    .rst_p  (pg_rst)
  );

  assign rx_ready = live_q &&
    (state_q == IDLE || state_q == ARG || state_q == RUN);
  assign accept   = rx_valid && rx_ready;
  assign arg_n    = (op_q == CMD_ADDR) ? IW'(AB) :
                    (op_q == CMD_DATA) ? IW'(DB) : IW'(CB);
  assign arg_last = (idx_q == arg_n - 1'b1);

  always_comb begin
    arg_nx = arg_q;
    arg_nx[{idx_q, 3'b000} +: 8] = rx_data;
  end

  // Built back to front so the first byte to send lands in the low byte.
  always_comb begin
    rr = '0;
    rn = '0;
    if (rx_valid) begin
      rr = {rr[RBW-9:0], RSP_ABORT};
      rn = rn + 1'b1;
    end
    if (!hlt) begin
      rr = {rr[RBW-9:0], RSP_HLT};
      rn = rn + 1'b1;
    end
    if (brk) begin
      rr = {rr[RBW-9:0], RSP_BRK};
      rn = rn + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      idx_q    <= '0;
      arg_q    <= '0;
      resp_q   <= '0;
      rn_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      cw_q     <= CW_DEFAULT;
      aoe_q    <= 1'b0;
      doe_q    <= 1'b0;
      cen_q    <= 1'b1;
      txd_q    <= '0;
      txv_q    <= 1'b0;
      live_q   <= 1'b0;
      start_q  <= 1'b0;
      second_q <= 1'b0;
      psel_q   <= PS_CLK;
    end else begin
      live_q  <= 1'b1;
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          op_q     <= rx_data;
          idx_q    <= '0;
          second_q <= 1'b0;
          unique case (rx_data)
            CMD_ADDR, CMD_DATA, CMD_MASK: state_q <= ARG;
            CMD_OUT: begin
              aoe_q   <= 1'b0;
              doe_q   <= 1'b0;
              state_q <= ARG;
            end
            CMD_FLOAT: begin
              aoe_q <= 1'b0;
              doe_q <= 1'b0;
            end
            CMD_RDA: begin
              resp_q  <= RBW'(addr_in);
              rn_q    <= RNW'(AB);
              state_q <= SEND;
            end
            CMD_RDD: begin
              resp_q  <= RBW'(data_in);
              rn_q    <= RNW'(DB);
              state_q <= SEND;
            end
            CMD_RDF: begin
              resp_q  <= RBW'(flags_in);
              rn_q    <= RNW'(FB);
              state_q <= SEND;
            end
            CMD_ID: begin
              resp_q  <= RBW'({RSP_ID1, RSP_ID0});
              rn_q    <= RNW'(2);
              state_q <= SEND;
            end
            CMD_CLK, CMD_TCYC: begin
              start_q <= 1'b1;
              psel_q  <= PS_CLK;
              state_q <= PULSE_HI;
            end
            CMD_ICLK: begin
              start_q <= 1'b1;
              psel_q  <= PS_ICLK;
              state_q <= PULSE_HI;
            end
            CMD_RST: begin
              start_q <= 1'b1;
              psel_q  <= PS_RST;
              state_q <= RSTP;
            end
            CMD_RUN: begin
              cen_q   <= 1'b0;
              state_q <= RUN;
            end
            CMD_NOP, CMD_NOP2: ;
            default: begin
              resp_q  <= RBW'(RSP_UNK);
              rn_q    <= RNW'(1);
              state_q <= SEND;
            end
          endcase
        end
        ARG: if (accept) begin
          arg_q <= arg_nx;
          idx_q <= idx_q + 1'b1;
          if (arg_last) begin
            state_q <= IDLE;
            unique case (op_q)
              CMD_ADDR: begin
                addr_q <= arg_nx[AW-1:0];
                aoe_q  <= 1'b1;
              end
              CMD_DATA: begin
                data_q <= arg_nx[DW-1:0];
                doe_q  <= 1'b1;
              end
              default: cw_q <= arg_nx[CW-1:0];
            endcase
          end
        end
        SEND: if (!txv_q || tx_ready) begin
          if (rn_q != '0) begin
            txd_q  <= resp_q[7:0];
            txv_q  <= 1'b1;
            resp_q <= {8'h00, resp_q[RBW-1:8]};
            rn_q   <= rn_q - 1'b1;
          end else begin
            txv_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        PULSE_HI: if (!start_q && !(pg_clk || pg_iclk)) begin
          state_q <= PULSE_LO;
        end
        PULSE_LO: if (!pg_busy) begin
          if ((op_q == CMD_TCYC || op_q == CMD_RUN) && !second_q) begin
            start_q  <= 1'b1;
            psel_q   <= PS_ICLK;
            second_q <= 1'b1;
            state_q  <= PULSE_HI;
          end else if (op_q == CMD_RUN) begin
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        // Decision point between T-cycles; a byte seen here aborts the run.
        RUN: if (brk || !hlt || rx_valid) begin
          cen_q   <= 1'b1;
          resp_q  <= rr;
          rn_q    <= rn;
          state_q <= SEND;
        end else begin
          start_q  <= 1'b1;
          psel_q   <= PS_CLK;
          second_q <= 1'b0;
          state_q  <= PULSE_HI;
        end
        RSTP: if (!start_q && !pg_busy) begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;
  assign addr_out  = addr_q;
  assign addr_oe   = aoe_q;
  assign data_out  = data_q;
  assign data_oe   = doe_q;
  assign ctrl_word = cw_q;
  assign ctrl_en   = cen_q;
  assign cpu_clk   = pg_clk;
  assign cpu_iclk  = pg_iclk;
  assign cpu_rst   = ~live_q | pg_rst;

endmodule

// File: tb/tb_cmd_engine.sv
// Directed bench for cmd_engine with a tx-byte scoreboard.
module tb_cmd_engine;
  import cmd_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int FW = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic [FW-1:0] flags_in = '0;
  logic          brk = 1'b0;
  logic          hlt = 1'b1;
  logic [AW-1:0] addr_out;
  logic          addr_oe;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic [CW-1:0] ctrl_word;
  logic          ctrl_en;
  logic          cpu_clk, cpu_iclk, cpu_rst;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int clk_rises, iclk_rises, clk_hi, rst_hi;
  bit en_bad, in_run;
  bit tx_fast = 1'b1;
  logic pc = 1'b0, pi = 1'b0, stall = 1'b0;
  logic [7:0] held = '0;
  logic [8:0] want;

  cmd_engine #(
    .AW(AW), .DW(DW), .CW(CW), .FW(FW), .PW(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .addr_in(addr_in), .data_in(data_in), .flags_in(flags_in),
    .brk(brk), .hlt(hlt),
    .addr_out(addr_out), .addr_oe(addr_oe),
    .data_out(data_out), .data_oe(data_oe),
    .ctrl_word(ctrl_word), .ctrl_en(ctrl_en),
    .cpu_clk(cpu_clk), .cpu_iclk(cpu_iclk), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept", {31'd0, rx_ready}, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rx_ready && !tx_valid && exp_q.size() == 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, n < 500}, 1);
  endtask

  task automatic clr_cnt();
    clk_rises  = 0;
    iclk_rises = 0;
    clk_hi     = 0;
    rst_hi     = 0;
    en_bad     = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = tx_fast ? 1'b1 : ~tx_ready;
  end

  // Output monitor: pulse counters, tx hold check, scoreboard compare.
  initial forever begin
    @(negedge clk);
    if (cpu_clk && !pc) clk_rises++;
    if (cpu_iclk && !pi) iclk_rises++;
    if (cpu_clk) clk_hi++;
    if (cpu_rst && rst) rst_hi++;
    if (in_run && (cpu_clk || cpu_iclk) && ctrl_en) en_bad = 1'b1;
    pc = cpu_clk;
    pi = cpu_iclk;
    if (stall) check("tx_hold", {tx_valid, tx_data}, {1'b1, held});
    stall = tx_valid && !tx_ready;
    held  = tx_data;
    if (tx_valid && tx_ready) begin
      want = 9'h100;
      if (exp_q.size() != 0) want = {1'b0, exp_q.pop_front()};
      check("tx_byte", {1'b0, tx_data}, want);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr_cnt();
    in_run = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_valid", {rx_ready, tx_valid}, 2'b00);
    check("rst_bus", {addr_out, data_out, addr_oe, data_oe}, '0);
    check("rst_ctrl", {ctrl_word, ctrl_en}, {32'hFFFF_FFFF, 1'b1});
    check("rst_cpu", {cpu_clk, cpu_iclk, cpu_rst}, 3'b001);
    rst = 1'b1;
    @(negedge clk);
    check("cpu_rst_release", {cpu_rst, rx_ready}, 2'b01);

    send_byte("A");
    send_byte(8'h34);
    check("addr_partial", {addr_out, addr_oe}, {16'h0000, 1'b0});
    send_byte(8'h12);
    check("addr_set", {addr_out, addr_oe}, {16'h1234, 1'b1});
    send_byte("f");
    check("float", {addr_oe, data_oe}, 2'b00);

    send_byte("M");
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("ctrl_partial", ctrl_word, 32'hFFFF_FFFF);
    send_byte(8'h04);
    check("ctrl_set", ctrl_word, 32'h0403_0201);

    send_byte("B");
    send_byte(8'h5A);
    check("data_set", {data_out, data_oe}, {8'h5A, 1'b1});
    send_byte("A");
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte("O");
    check("out_clear", {addr_oe, data_oe}, 2'b00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("out_ctrl", {ctrl_word, addr_out}, {32'h4433_2211, 16'hABCD});

    addr_in = 16'hBEEF;
    tx_fast = 1'b0;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    send_byte("a");
    addr_in = 16'h0000;
    wait_idle();
    tx_fast = 1'b1;

    data_in  = 8'hC3;
    flags_in = 4'hA;
    exp_q.push_back(8'hC3);
    send_byte("b");
    wait_idle();
    exp_q.push_back(8'h0A);
    send_byte("s");
    wait_idle();
    exp_q.push_back("V");
    exp_q.push_back("M");
    send_byte("I");
    wait_idle();
    exp_q.push_back("?");
    send_byte("q");
    wait_idle();
    send_byte("N");
    send_byte(8'hFF);
    wait_idle();

    clr_cnt();
    send_byte("c");
    wait_idle();
    check("c_pulse", {clk_rises, clk_hi, iclk_rises}, {32'd1, PW, 32'd0});
    clr_cnt();
    send_byte("C");
    wait_idle();
    check("C_pulse", {clk_rises, iclk_rises}, {32'd0, 32'd1});
    clr_cnt();
    send_byte("T");
    wait_idle();
    check("T_pulse", {clk_rises, iclk_rises}, {32'd1, 32'd1});
    clr_cnt();
    send_byte("Z");
    wait_idle();
    check("Z_pulse", rst_hi, PW);

    clr_cnt();
    in_run = 1'b1;
    exp_q.push_back("K");
    send_byte("R");
    n = 0;
    while (iclk_rises < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    while (cpu_iclk && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("run_reach3", {31'd0, n < 300}, 1);
    brk = 1'b1;
    wait_idle();
    brk = 1'b0;
    in_run = 1'b0;
    check("run_brk_cnt", {clk_rises, iclk_rises}, {32'd3, 32'd3});
    check("run_en_low", {en_bad, ctrl_en}, 2'b01);

    clr_cnt();
    in_run = 1'b1;
    exp_q.push_back("X");
    send_byte("R");
    n = 0;
    while (clk_rises < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    send_byte(8'h55);
    wait_idle();
    in_run = 1'b0;
    check("run_abort_cnt", {clk_rises, iclk_rises}, {32'd2, 32'd2});
    check("run_abort_en", {en_bad, ctrl_en}, 2'b01);

    clr_cnt();
    hlt = 1'b0;
    exp_q.push_back("H");
    send_byte("R");
    wait_idle();
    check("run_hlt0", clk_rises, 0);
    brk = 1'b1;
    exp_q.push_back("K");
    exp_q.push_back("H");
    send_byte("R");
    wait_idle();
    check("run_both", {clk_rises, ctrl_en}, {32'd0, 1'b1});
    brk = 1'b0;
    hlt = 1'b1;

    send_byte("B");
    rst = 1'b0;
    @(negedge clk);
    check("midrst", {data_oe, data_out, cpu_rst, tx_valid}, {1'b0, 8'h00, 1'b1, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back("?");
    send_byte(8'h77);
    wait_idle();
    check("midrst_lost", {data_oe, data_out}, {1'b0, 8'h00});

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
